// File: rtl/rr_grant_issuer.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_issuer
// Brief    : Grant side of a round-robin arbiter. Drives the priority index
//            to an external combinational priority coder, takes the coder's
//            winning index back, issues a registered one-hot grant, holds it
//            until done / request drop / hold timeout, then rotates priority.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_issuer #(
  parameter int REQCNT   = 3,
  parameter int REQWIDTH = $clog2(REQCNT),
  parameter int MAXHOLD  = 16,
  parameter int HOLDW    = $clog2(MAXHOLD + 1)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [REQCNT-1:0]   req_i,
  input  logic [REQCNT-1:0]   done_i,
  input  logic [REQWIDTH-1:0] data_num_i,
  output logic [REQWIDTH-1:0] prior_o,
  output logic [REQCNT-1:0]   gnt_o,
  output logic                gnt_valid_o,
  output logic [REQWIDTH-1:0] gnt_num_o,
  output logic                timeout_o
);

  localparam logic [1:0] C_ST_IDLE  = 2'd0;
  localparam logic [1:0] C_ST_GRANT = 2'd1;
  localparam logic [1:0] C_ST_GAP   = 2'd2;

  localparam logic [REQWIDTH:0]   C_REQCNT_EXT = (REQWIDTH + 1)'(REQCNT);
  localparam logic [REQWIDTH-1:0] C_LAST_IDX   = REQWIDTH'(REQCNT - 1);
  localparam logic [HOLDW-1:0]    C_CNT_LAST   = HOLDW'(MAXHOLD - 1);
  localparam logic [REQCNT-1:0]   C_ONE_HOT0   = REQCNT'(1);

  logic [1:0]          state_q, state_d;
  logic [REQCNT-1:0]   gnt_q, gnt_d;
  logic [REQWIDTH-1:0] num_q, num_d;
  logic [REQWIDTH-1:0] prior_q, prior_d;
  logic [HOLDW-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  logic w_in_range;
  logic w_start;
  logic w_done;
  logic w_drop;
  logic w_last;
  logic w_release;
  logic w_timeout;

  // The coder's answer is only trusted when it is in range and actually requesting.
  assign w_in_range = ({1'b0, data_num_i} < C_REQCNT_EXT);
  assign w_start    = (|req_i) && w_in_range && req_i[data_num_i];

  // Release sources for the current owner; done/drop take precedence over timeout.
  assign w_done    = done_i[num_q];
  assign w_drop    = ~req_i[num_q];
  assign w_last    = (cnt_q == C_CNT_LAST);
  assign w_release = w_done | w_drop | w_last;
  assign w_timeout = w_last & ~w_done & ~w_drop;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= C_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> GRANT -> GAP -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_IDLE:  if (w_start)   state_d = C_ST_GRANT;
      C_ST_GRANT: if (w_release) state_d = C_ST_GAP;
      C_ST_GAP:                  state_d = C_ST_IDLE;
      default:                   state_d = C_ST_IDLE;
    endcase
  end

  // Output / datapath next values; every output is taken from a register.
  always_comb begin
    gnt_d     = gnt_q;
    num_d     = num_q;
    prior_d   = prior_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      C_ST_IDLE: begin
        if (w_start) begin
          num_d = data_num_i;
          gnt_d = C_ONE_HOT0 << data_num_i;
          cnt_d = '0;
        end
      end
      C_ST_GRANT: begin
        if (w_release) begin
          gnt_d     = '0;
          num_d     = '0;
          prior_d   = (num_q == C_LAST_IDX) ? '0 : num_q + 1'b1;
          timeout_d = w_timeout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  // Output and datapath registers; reset drops the grant without waiting for a clock.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      gnt_q     <= '0;
      num_q     <= '0;
      prior_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      num_q     <= num_d;
      prior_q   <= prior_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = |gnt_q;
  assign gnt_num_o   = num_q;
  assign prior_o     = prior_q;
  assign timeout_o   = timeout_q;

endmodule
`default_nettype wire
